// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: default width,
// FSM state encoding and the bubble instruction used on reset.
package if_pkg;

    localparam int IF_XLEN = 32;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } if_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds one fetched instruction and its PC for
// decode, with fill, consume (id_ready) and flush control.
module if_id_reg
    import if_pkg::*;
#(
    parameter int XLEN = IF_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fill,
    input  logic            flush,
    input  logic            id_ready,
    input  logic [XLEN-1:0] fill_instr,
    input  logic [XLEN-1:0] fill_pc,
    output logic            id_valid,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;

    // Flush beats fill; a fill replaces any entry being consumed; otherwise a
    // consumed entry empties the register and an unconsumed one holds.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (fill) begin
            valid_d = 1'b1;
            instr_d = fill_instr;
            pc_d    = fill_pc;
        end else if (id_ready && valid_q) begin
            valid_d = 1'b0;
        end
    end

    // Register update with synchronous active-low reset to an empty NOP slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= XLEN'(NOP);
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign id_valid = valid_q;
    assign id_instr = instr_q;
    assign id_pc    = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: steers the external PC counter, issues one
// outstanding fetch at a time to instruction memory and fills the IF/ID
// register, honouring decode backpressure and redirects from later stages.
module if_stage
    import if_pkg::*;
#(
    parameter int              XLEN     = IF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_en,
    output logic            pc_load,
    output logic [XLEN-1:0] pc_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    output logic            imem_rsp_ready,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc
);

    if_state_e       state_q, state_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            space;
    logic            fill;
    logic            flush;

    // The IF/ID slot can accept a new instruction when empty or draining.
    assign space = !id_valid || id_ready;

    // Next-state and counter/memory control; a redirect overrides everything
    // except the boot load.
    always_comb begin
        state_d        = state_q;
        pend_pc_d      = pend_pc_q;
        pc_en          = 1'b0;
        pc_load        = 1'b0;
        pc_target      = '0;
        imem_req_valid = 1'b0;
        imem_addr      = '0;
        imem_rsp_ready = 1'b0;
        fill           = 1'b0;
        flush          = 1'b0;

        case (state_q)
            S_BOOT: begin
                pc_en     = 1'b1;
                pc_load   = 1'b1;
                pc_target = RESET_PC;
                state_d   = S_REQ;
            end
            S_REQ: begin
                imem_addr      = pc_in;
                imem_req_valid = space && !redirect_valid;
                if (imem_req_valid && imem_req_ready) begin
                    pend_pc_d = pc_in;
                    pc_en     = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                imem_rsp_ready = space;
                if (imem_rsp_valid && imem_rsp_ready) begin
                    fill    = !redirect_valid;
                    state_d = S_REQ;
                end else if (redirect_valid) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                imem_rsp_ready = 1'b1;
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        if (redirect_valid && state_q != S_BOOT) begin
            pc_en     = 1'b1;
            pc_load   = 1'b1;
            pc_target = redirect_pc;
            flush     = 1'b1;
        end
    end

    // FSM state and the PC of the outstanding request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_BOOT;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    if_id_reg #(
        .XLEN(XLEN)
    ) u_if_id_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .fill      (fill),
        .flush     (flush),
        .id_ready  (id_ready),
        .fill_instr(imem_rsp_data),
        .fill_pc   (pend_pc_q),
        .id_valid  (id_valid),
        .id_instr  (id_instr),
        .id_pc     (id_pc)
    );

endmodule
